cpu_debug_ocimem_access: RTL and testbench

- Debug on-chip-memory stage directly downstream of the CPU debug-slave wrapper, in the system clock domain.
- Consumes the wrapper's jdo bus and its ocimem take_action / take_no_action strobes.
- Owns a single-port debug RAM and the monitor data/address registers; returns MonDReg to the wrapper for JTAG shift-out.
- Also exposes a CPU-side Avalon-MM slave to the same RAM; JTAG accesses have priority.

---
 rtl/cpu_debug_ocimem_access.sv | 144 ++++++++++++++
 tb/tb_cpu_debug_ocimem_access.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_ocimem_access.sv
`default_nettype none
// ============================================================================
// Module   : cpu_debug_ocimem_access
// Brief    : Debug on-chip memory behind the JTAG debug slave, with a CPU
//            Avalon-MM port into the same RAM. JTAG traffic always goes first.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_debug_ocimem_access #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] INIT_MONDREG = 32'h0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_J_READ    = 3'd1;
    localparam logic [2:0] c_ST_J_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_J_WRITE   = 3'd3;
    localparam logic [2:0] c_ST_C_READ    = 3'd4;
    localparam int         c_DEPTH        = 1 << ADDR_W;

    logic [2:0]        r_state;
    logic              r_rd_pend;
    logic              r_wr_pend;
    logic [31:0]       r_mem [c_DEPTH];
    logic [31:0]       r_ram_q;

    logic              w_strobe_a;
    logic              w_strobe_na;
    logic              w_strobe_b;
    logic              w_rd_set;
    logic              w_jtag_req;
    logic              w_idle_free;
    logic              w_cpu_wr;
    logic              w_cpu_rd;
    logic              w_jtag_ram;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata;
    logic              w_unused_jdo;

    // A strobe whose pend flag is already set is absorbed; ocimem_b beats both a-strobes.
    assign w_strobe_b  = take_action_ocimem_b & ~r_wr_pend;
    assign w_strobe_a  = take_action_ocimem_a & ~take_action_ocimem_b & ~r_rd_pend;
    assign w_strobe_na = take_no_action_ocimem_a & ~take_action_ocimem_b & ~r_rd_pend;
    assign w_rd_set    = (w_strobe_a & jdo[35]) | w_strobe_na;

    // Strobes arriving this cycle already lock the CPU out, so JTAG cannot lose a race.
    assign w_jtag_req  = r_rd_pend | r_wr_pend | w_strobe_b | w_rd_set;
    assign w_idle_free = (r_state == c_ST_IDLE) & ~w_jtag_req;
    assign w_cpu_wr    = w_idle_free & avs_write;
    assign w_cpu_rd    = w_idle_free & ~avs_write & avs_read;

    assign w_jtag_ram  = (r_state == c_ST_J_WRITE) | (r_state == c_ST_J_READ);
    assign w_ram_we    = (r_state == c_ST_J_WRITE) | w_cpu_wr;
    assign w_ram_addr  = w_jtag_ram ? MonAReg : avs_address;
    assign w_ram_be    = (r_state == c_ST_J_WRITE) ? 4'hF : avs_byteenable;
    assign w_ram_wdata = (r_state == c_ST_J_WRITE) ? MonDReg : avs_writedata;

    assign avs_waitrequest = ~(w_cpu_wr | (r_state == c_ST_C_READ));
    assign jtag_busy       = r_rd_pend | r_wr_pend |
                             ((r_state != c_ST_IDLE) & (r_state != c_ST_C_READ));
    assign w_unused_jdo    = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && w_ram_be[i]) begin
                r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
        r_ram_q <= r_mem[w_ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_rd_pend    <= 1'b0;
            r_wr_pend    <= 1'b0;
            MonDReg      <= INIT_MONDREG;
            MonAReg      <= '0;
            avs_readdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_wr_pend) begin
                        r_state <= c_ST_J_WRITE;
                    end else if (r_rd_pend) begin
                        r_state <= c_ST_J_READ;
                    end else if (w_cpu_rd) begin
                        r_state <= c_ST_C_READ;
                    end
                end
                c_ST_J_WRITE: begin
                    MonAReg   <= MonAReg + 1'b1;
                    r_wr_pend <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                c_ST_J_READ: begin
                    r_rd_pend <= 1'b0;
                    r_state   <= c_ST_J_CAPTURE;
                end
                c_ST_J_CAPTURE: begin
                    MonDReg <= r_ram_q;
                    MonAReg <= MonAReg + 1'b1;
                    r_state <= c_ST_IDLE;
                end
                c_ST_C_READ: begin
                    avs_readdata <= r_ram_q;
                    r_state      <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
            // New strobe loads override the FSM's own register updates in the same cycle.
            if (w_strobe_a) begin
                MonAReg <= jdo[26 +: ADDR_W];
            end
            if (w_rd_set) begin
                r_rd_pend <= 1'b1;
            end
            if (w_strobe_b) begin
                MonDReg   <= jdo[34:3];
                r_wr_pend <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_ocimem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_debug_ocimem_access
// Brief    : Directed plus randomized bench against a word-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_debug_ocimem_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy;

    cpu_debug_ocimem_access #(.ADDR_W(8), .INIT_MONDREG(32'h0)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .avs_address            (avs_address),
        .avs_read               (avs_read),
        .avs_write              (avs_write),
        .avs_writedata          (avs_writedata),
        .avs_byteenable         (avs_byteenable),
        .avs_readdata           (avs_readdata),
        .avs_waitrequest        (avs_waitrequest),
        .MonDReg                (MonDReg),
        .MonAReg                (MonAReg),
        .jtag_busy              (jtag_busy)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents plus the two monitor registers.
    logic [31:0] m_mem [256];
    bit          m_valid [256];
    logic [7:0]  known_q [$];
    logic [7:0]  m_adr;
    logic [31:0] m_dreg;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end
        if (!m_valid[a]) begin
            m_valid[a] = 1'b1;
            known_q.push_back(a);
        end
    endtask

    task automatic wait_jtag_idle();
        for (int i = 0; i < 20 && jtag_busy; i++) tick();
        check("jtag_idle", 32'(jtag_busy), 32'd0);
    endtask

    task automatic jtag_load(input logic [7:0] a);
        jdo = '0;
        jdo[33:26] = a;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
        m_adr = a;
        check("jload_adr", 32'(MonAReg), 32'(m_adr));
    endtask

    task automatic jtag_write_data(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        check("jwr_busy", 32'(jtag_busy), 32'd1);
        wait_jtag_idle();
        model_store(m_adr, d, 4'hF);
        m_dreg = d;
        m_adr  = m_adr + 8'd1;
        check("jwr_adr", 32'(MonAReg), 32'(m_adr));
        check("jwr_dreg", MonDReg, m_dreg);
    endtask

    // Read data must appear exactly three edges after the strobe edge.
    task automatic jtag_read(input bit use_start, input logic [7:0] a);
        logic [31:0] exp_d;
        logic [31:0] old_d;
        jdo = '0;
        if (use_start) begin
            jdo[33:26] = a;
            jdo[35] = 1'b1;
            take_action_ocimem_a = 1'b1;
            m_adr = a;
        end else begin
            take_no_action_ocimem_a = 1'b1;
        end
        exp_d = m_mem[m_adr];
        old_d = m_dreg;
        tick();
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
        tick();
        tick();
        check("jrd_early", MonDReg, old_d);
        tick();
        check("jrd_data", MonDReg, exp_d);
        m_dreg = exp_d;
        m_adr  = m_adr + 8'd1;
        check("jrd_adr", 32'(MonAReg), 32'(m_adr));
        check("jrd_idle", 32'(jtag_busy), 32'd0);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a;
        avs_writedata = d;
        avs_byteenable = be;
        avs_write = 1'b1;
        #1;
        for (int i = 0; i < 20 && avs_waitrequest; i++) begin
            tick();
            #1;
        end
        check("cpu_wr_accept", 32'(avs_waitrequest), 32'd0);
        tick();
        avs_write = 1'b0;
        model_store(a, d, be);
    endtask

    task automatic cpu_read(input logic [7:0] a, output int waited);
        avs_address = a;
        avs_read = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (avs_waitrequest && waited < 30);
        check("cpu_rd_accept", 32'(avs_waitrequest), 32'd0);
        avs_read = 1'b0;
        tick();
        check("cpu_rd_data", avs_readdata, m_mem[a]);
        check("cpu_rd_one_cycle", 32'(avs_waitrequest), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;

        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = 4'hF;
        m_adr = '0;
        m_dreg = '0;
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_monareg", 32'(MonAReg), 32'h0);
        check("rst_waitreq", 32'(avs_waitrequest), 32'd1);
        check("rst_busy", 32'(jtag_busy), 32'd0);
        check("rst_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        check("post_rst_waitreq", 32'(avs_waitrequest), 32'd1);

        // JTAG write then CPU read-back; uncontended read needs one stall edge
        jtag_load(8'h10);
        jtag_write_data(32'hDEADBEEF);
        check("jwr_adr_11", 32'(MonAReg), 32'h11);
        cpu_read(8'h10, w);
        check("cpu_rd_latency", 32'(w), 32'd1);
        check("cpu_rd_deadbeef", avs_readdata, 32'hDEADBEEF);

        // Sequential JTAG reads
        cpu_write(8'h20, 32'd1, 4'hF);
        cpu_write(8'h21, 32'd2, 4'hF);
        cpu_write(8'h22, 32'd3, 4'hF);
        jtag_read(1'b1, 8'h20);
        check("seq_rd1", MonDReg, 32'd1);
        jtag_read(1'b0, 8'h00);
        check("seq_rd2", MonDReg, 32'd2);
        jtag_read(1'b0, 8'h00);
        check("seq_rd3", MonDReg, 32'd3);
        check("seq_adr_end", 32'(MonAReg), 32'h23);

        // Address wrap
        jtag_load(8'hFF);
        jtag_write_data(32'h0BADF00D);
        check("wrap_adr", 32'(MonAReg), 32'h00);
        jtag_write_data(32'hCAFEF00D);
        cpu_read(8'h00, w);
        check("wrap_ram0", avs_readdata, 32'hCAFEF00D);

        // Byte-lane CPU write
        cpu_write(8'h05, 32'h0, 4'hF);
        cpu_write(8'h05, 32'hAABBCCDD, 4'b0010);
        check("be_model", m_mem[8'h05], 32'h0000CC00);

        // CPU read arriving in the same cycle as a JTAG write strobe
        jtag_load(8'h40);
        jdo = '0;
        jdo[34:3] = 32'h12345678;
        take_action_ocimem_b = 1'b1;
        avs_address = 8'h05;
        avs_read = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        w = 1;
        check("cont_stall", 32'(avs_waitrequest), 32'd1);
        check("cont_busy", 32'(jtag_busy), 32'd1);
        while (avs_waitrequest && w < 30) begin
            tick();
            w++;
        end
        check("cont_latency", 32'(w), 32'd4);
        check("cont_jtag_done", 32'(jtag_busy), 32'd0);
        avs_read = 1'b0;
        tick();
        check("cont_rd_data", avs_readdata, 32'h0000CC00);
        model_store(8'h40, 32'h12345678, 4'hF);
        m_dreg = 32'h12345678;
        m_adr = 8'h41;
        check("cont_adr", 32'(MonAReg), 32'h41);
        cpu_read(8'h40, w);

        // Reset during J_CAPTURE
        jdo = '0;
        jdo[33:26] = 8'h10;
        jdo[35] = 1'b1;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_mondreg", MonDReg, 32'h0);
        check("midrst_monareg", 32'(MonAReg), 32'h0);
        check("midrst_busy", 32'(jtag_busy), 32'd0);
        check("midrst_waitreq", 32'(avs_waitrequest), 32'd1);
        tick();
        reset_n = 1'b1;
        m_dreg = 32'h0;
        m_adr = 8'h0;
        tick();
        jtag_read(1'b1, 8'h10);
        check("midrst_after", MonDReg, 32'hDEADBEEF);

        // Randomized operation mix against the model
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 8'($urandom);
                    d = $urandom;
                    jtag_load(a);
                    jtag_write_data(d);
                end
                1: begin
                    a = 8'($urandom);
                    d = $urandom;
                    be = m_valid[a] ? 4'($urandom) : 4'hF;
                    cpu_write(a, d, be);
                end
                2: begin
                    a = known_q[$urandom_range(0, known_q.size() - 1)];
                    cpu_read(a, w);
                end
                default: begin
                    if (m_valid[m_adr] && $urandom_range(0, 1) == 1) begin
                        jtag_read(1'b0, 8'h00);
                    end else begin
                        a = known_q[$urandom_range(0, known_q.size() - 1)];
                        jtag_read(1'b1, a);
                    end
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
